// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response signals of alu_arbiter.
// master = environment (requesters + ALU + response sink), slave = the arbiter.
interface alu_arbiter_if;
  logic        r0_valid;
  logic        r0_ready;
  logic [3:0]  r0_op;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic        r1_valid;
  logic        r1_ready;
  logic [3:0]  r1_op;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    output r1_valid, r1_op, r1_a, r1_b,
    input  r0_ready, r1_ready,
    input  alu_start, alu_op, alu_a, alu_b,
    output alu_done, alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    input  r1_valid, r1_op, r1_a, r1_b,
    output r0_ready, r1_ready,
    output alu_start, alu_op, alu_a, alu_b,
    input  alu_done, alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between two requesters,
// one operation in flight, with illegal-op and timeout error responses.
module alu_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          state;
  logic            last_grant;
  logic [CW-1:0]   wait_cnt;
  logic            cur_id;
  logic            grant0;
  logic            grant1;
  logic [3:0]      sel_op;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

  logic            alu_start_q;
  logic [3:0]      alu_op_q;
  logic [31:0]     alu_a_q;
  logic [31:0]     alu_b_q;
  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [31:0]     rsp_result_q;
  logic            rsp_zero_q;
  logic            rsp_err_q;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Ready is gated by rst_n so no grant is visible while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && rst_n) begin
      if (bus.r0_valid && bus.r1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.r0_valid;
        grant1 = bus.r1_valid;
      end
    end
  end

  always_comb begin
    sel_op = grant1 ? bus.r1_op : bus.r0_op;
    sel_a  = grant1 ? bus.r1_a  : bus.r0_a;
    sel_b  = grant1 ? bus.r1_b  : bus.r0_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      wait_cnt     <= '0;
      cur_id       <= 1'b0;
      alu_start_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      alu_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            cur_id      <= grant1;
            last_grant  <= grant1;
            alu_op_q    <= sel_op;
            alu_a_q     <= sel_a;
            alu_b_q     <= sel_b;
            // Strobe is registered, so legality is decided at accept time.
            alu_start_q <= op_legal(sel_op);
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_legal(alu_op_q)) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= cur_id;
            rsp_result_q <= 32'h1;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b1;
            state        <= RESP;
          end
        end
        WAIT: begin
          if (bus.alu_done) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= cur_id;
            rsp_result_q <= bus.alu_result;
            rsp_zero_q   <= bus.alu_zero;
            rsp_err_q    <= 1'b0;
            state        <= RESP;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= cur_id;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b1;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r0_ready   = grant0;
  assign bus.r1_ready   = grant1;
  assign bus.alu_start  = alu_start_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: requester queues, an ALU model with
// programmable done latency, and expected responses checked on rsp_valid.
module tb_alu_arbiter;

  localparam int TO = 4;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        zero;
    logic        err;
    int          lat;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   alu_lat = 2;
  int   starts = 0;
  int   done_cyc = 0;
  logic pend = 1'b0;
  logic [31:0] m_res = '0;
  logic prev_start = 1'b0;
  logic lg = 1'b1;
  logic acc0 = 1'b0;
  logic acc1 = 1'b0;
  req_t q0[$];
  req_t q1[$];
  exp_t exp_q[$];
  logic glog[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic id, input req_t r, input int t);
    exp_t e;
    e.id = id;
    e.t  = t;
    if (!(r.op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110})) begin
      e.result = 32'h1; e.zero = 1'b0; e.err = 1'b1; e.lat = 2;
    end else if (alu_lat <= TO) begin
      e.result = alu_fn(r.op, r.a, r.b);
      e.zero   = (e.result == 32'h0);
      e.err    = 1'b0;
      e.lat    = 2 + alu_lat;
    end else begin
      e.result = 32'h0; e.zero = 1'b0; e.err = 1'b1; e.lat = 2 + TO;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Requester and ALU drivers, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (acc0) begin q0.delete(0); acc0 = 1'b0; end
    if (acc1) begin q1.delete(0); acc1 = 1'b0; end
    bus.r0_valid = (q0.size() != 0);
    if (q0.size() != 0) begin bus.r0_op = q0[0].op; bus.r0_a = q0[0].a; bus.r0_b = q0[0].b; end
    bus.r1_valid = (q1.size() != 0);
    if (q1.size() != 0) begin bus.r1_op = q1[0].op; bus.r1_a = q1[0].a; bus.r1_b = q1[0].b; end
    if (pend && cyc == done_cyc) begin
      bus.alu_done   = 1'b1;
      bus.alu_result = m_res;
      bus.alu_zero   = (m_res == 32'h0);
      pend = 1'b0;
    end else begin
      bus.alu_done = 1'b0;
    end
  end

  // Monitor: handshakes, ALU issue and responses, sampled on the falling edge.
  always @(negedge clk) begin
    logic g;
    logic pred;
    req_t r;
    exp_t e;
    if (rst_n) begin
      if (bus.r0_ready || bus.r1_ready) begin
        g    = bus.r1_ready;
        pred = (bus.r0_valid && bus.r1_valid) ? ~lg : bus.r1_valid;
        check("grant", {62'd0, bus.r0_ready, bus.r1_ready}, pred ? 64'd1 : 64'd2);
        check("ready_idle", exp_q.size(), 0);
        lg = pred;
        glog.push_back(g);
        if ((g ? q1.size() : q0.size()) == 0) begin
          check("ready_novalid", 1, 0);
        end else begin
          r = g ? q1[0] : q0[0];
          exp_q.push_back(mk_exp(g, r, cyc));
          if (g) acc1 = 1'b1; else acc0 = 1'b1;
        end
      end
      if (bus.alu_start) begin
        starts++;
        if (prev_start) check("start_pulse", 1, 0);
        m_res    = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
        done_cyc = cyc + alu_lat;
        pend     = 1'b1;
      end
      prev_start = bus.alu_start;
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", bus.rsp_id, e.id);
          check("rsp_result", bus.rsp_result, e.result);
          check("rsp_zero", bus.rsp_zero, e.zero);
          check("rsp_err", bus.rsp_err, e.err);
          check("rsp_latency", cyc - e.t, e.lat);
        end
      end
    end
  end

  task automatic drain(input int maxc);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("drain", q0.size() + q1.size() + exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s0;
    int n;
    bus.r0_valid = 1'b0; bus.r0_op = '0; bus.r0_a = '0; bus.r0_b = '0;
    bus.r1_valid = 1'b0; bus.r1_op = '0; bus.r1_a = '0; bus.r1_b = '0;
    bus.alu_done = 1'b0; bus.alu_result = '0; bus.alu_zero = 1'b0;

    // Tie from reset: both SUB 0F-0F
    q0.push_back('{op: 4'b0110, a: 32'h0F, b: 32'h0F});
    q1.push_back('{op: 4'b0110, a: 32'h0F, b: 32'h0F});
    repeat (3) @(negedge clk);
    check("rst_r0_ready", bus.r0_ready, 0);
    check("rst_r1_ready", bus.r1_ready, 0);
    check("rst_alu_start", bus.alu_start, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_alu_op", bus.alu_op, 0);
    rst_n = 1'b1;
    drain(100);
    check("tie_order", {62'd0, glog[0], glog[1]}, 64'b01);

    // Sustained contention: grants alternate 0,1,0,1
    q0.push_back('{op: 4'b0010, a: 32'h1, b: 32'h2});
    q0.push_back('{op: 4'b0000, a: 32'hF0F0_00FF, b: 32'h0FF0_0F0F});
    q1.push_back('{op: 4'b0001, a: 32'hA000_0000, b: 32'h0000_0005});
    q1.push_back('{op: 4'b0110, a: 32'h0, b: 32'h1});
    drain(200);
    check("alternate", {60'd0, glog[2], glog[3], glog[4], glog[5]}, 64'b0101);

    // Single r0 ADD 5+7, done two cycles after start
    s0 = starts;
    q0.push_back('{op: 4'b0010, a: 32'd5, b: 32'd7});
    drain(100);
    check("single_starts", starts - s0, 1);

    // Illegal op from r1: no ALU issue
    s0 = starts;
    q1.push_back('{op: 4'b0101, a: 32'h3, b: 32'h4});
    drain(100);
    check("illegal_nostart", starts - s0, 0);

    // Timeout: done arrives well after the abort and must be ignored
    s0 = starts;
    alu_lat = 9;
    q0.push_back('{op: 4'b0010, a: 32'h10, b: 32'h20});
    drain(100);
    repeat (10) @(negedge clk);
    check("timeout_starts", starts - s0, 1);
    check("late_done_consumed", pend, 0);

    // Reset during WAIT, then an r1-only request
    alu_lat = 1000;
    q0.push_back('{op: 4'b0010, a: 32'h1, b: 32'h2});
    n = 0;
    while (exp_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    check("wait_accept", exp_q.size(), 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_alu_start", bus.alu_start, 0);
    check("midrst_alu_op", bus.alu_op, 0);
    check("midrst_r0_ready", bus.r0_ready, 0);
    exp_q.delete();
    pend = 1'b0;
    lg = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    alu_lat = 3;
    q1.push_back('{op: 4'b0010, a: 32'd100, b: 32'd23});
    drain(100);
    check("post_rst_grant", glog[glog.size()-1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
